matmul2x2_ctrl: RTL and testbench

MATMUL2X2_CTRL -- requirements
Module: matmul2x2_ctrl

---
 rtl/matmul2x2_ctrl.sv | 146 ++++++++++++++
 tb/tb_matmul2x2_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/matmul2x2_ctrl.sv
// matmul2x2_ctrl
//   Sequences a 2x2 by 2x2 unsigned matrix multiply (2-bit elements) through
//   one shared external 2x2-bit multiplier. Each result element takes two
//   steps: a product load (t=0) and a product accumulate and write (t=1).
//   The whole matrix therefore takes 8 MUL cycles.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand matrices presented
//   in_ready   out  controller can accept operands (IDLE, rst low)
//   a_mat      in   8   A packed {a11,a10,a01,a00}
//   b_mat      in   8   B packed {b11,b10,b01,b00}
//   mul_a      out  2   first operand to the shared multiplier
//   mul_b      out  2   second operand to the shared multiplier
//   mul_p      in   4   combinational product mul_a*mul_b
//   busy       out  high while in MUL
//   out_valid  out  c_mat holds a completed result (DONE)
//   out_ready  in   consumer accepts result
//   c_mat      out  4*ACC_W  C = A x B packed {c11,c10,c01,c00}
module matmul2x2_ctrl #(
  parameter int ACC_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         a_mat,
  input  logic [7:0]         b_mat,
  output logic [1:0]         mul_a,
  output logic [1:0]         mul_b,
  input  logic [3:0]         mul_p,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*ACC_W-1:0] c_mat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [2:0]         k_q;
  logic [3:0]         psum_q;
  logic [7:0]         a_q;
  logic [7:0]         b_q;
  logic [4*ACC_W-1:0] c_q;

  logic [1:0] e_s;
  logic       t_s;
  logic [1:0] op_a_s;
  logic [1:0] op_b_s;
  logic [4:0] sum_s;

  // Selects 2-bit element idx from a packed 2x2 matrix; idx = 2*row + col.
  function automatic logic [1:0] elem2(input logic [7:0] m, input logic [1:0] idx);
    case (idx)
      2'd0:    return m[1:0];
      2'd1:    return m[3:2];
      2'd2:    return m[5:4];
      2'd3:    return m[7:6];
      default: return 2'b00;
    endcase
  endfunction

  // Step decode: element e = {i,j} from k[2:1], term t from k[0].
  // The operands are a_{i,t} and b_{t,j}, taken from the registered matrices.
  always_comb begin
    e_s    = k_q[2:1];
    t_s    = k_q[0];
    op_a_s = elem2(a_q, {e_s[1], t_s});
    op_b_s = elem2(b_q, {t_s, e_s[0]});
    sum_s  = {1'b0, psum_q} + {1'b0, mul_p};
  end

  // Output decode from registered state. A high rst forces every handshake
  // and operand output low, even before the reset edge lands.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    mul_a     = 2'b00;
    mul_b     = 2'b00;
    if (!rst) begin
      in_ready  = (state_q == IDLE);
      busy      = (state_q == MUL);
      out_valid = (state_q == DONE);
      if (state_q == MUL) begin
        mul_a = op_a_s;
        mul_b = op_b_s;
      end else begin
        mul_a = 2'b00;
        mul_b = 2'b00;
      end
    end else begin
      in_ready = 1'b0;
    end
  end

  assign c_mat = c_q;

  // Controller FSM together with its operand, step and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      psum_q  <= 4'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      c_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_mat;
            b_q     <= b_mat;
            k_q     <= 3'd0;
            state_q <= MUL;
          end
        end
        MUL: begin
          k_q <= k_q + 3'd1;
          if (!t_s) begin
            psum_q <= mul_p;
          end else begin
            // The maximum sum is 9+9=18, so 5 bits always hold it.
            c_q[e_s*ACC_W +: ACC_W] <= ACC_W'(sum_s);
          end
          if (k_q == 3'd7) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul2x2_ctrl.sv
module tb_matmul2x2_ctrl;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     a_mat;
  logic [7:0]     b_mat;
  logic [1:0]     mul_a;
  logic [1:0]     mul_b;
  logic [3:0]     mul_p;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [4*W-1:0] c_mat;

  int checks = 0;
  int errors = 0;

  matmul2x2_ctrl #(.ACC_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .c_mat(c_mat)
  );

  // Behaviour of the shared external multiplier.
  assign mul_p = {2'b00, mul_a} * {2'b00, mul_b};

  always #5 clk = ~clk;

  function automatic logic [4*W-1:0] pack(input int c11, input int c10,
                                          input int c01, input int c00);
    return {W'(c11), W'(c10), W'(c01), W'(c00)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operands expected on the multiplier for k = 0..7 with A=8'h39, B=8'hC6.
  logic [1:0] exp_a [8] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0};
  logic [1:0] exp_b [8] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
  logic       saw_valid;

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a_mat = 8'h39; b_mat = 8'hC6;
    tick(); tick();
    // Reset state: every output is low and c_mat is cleared.
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mul_a",     32'(mul_a),     32'd0);
    chk("rst_mul_b",     32'(mul_b),     32'd0);
    chk("rst_c_mat",     32'(c_mat),     32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Basic test. out_ready is held high during MUL, where it is ignored.
    // The operands change right after the accept edge and must be ignored.
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; a_mat = 8'h00; b_mat = 8'h00;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("basic_busy_k%0d", k),  32'(busy),      32'd1);
      chk($sformatf("basic_ov_k%0d", k),    32'(out_valid), 32'd0);
      chk($sformatf("basic_ir_k%0d", k),    32'(in_ready),  32'd0);
      chk($sformatf("basic_mul_a_k%0d", k), 32'(mul_a),     32'(exp_a[k]));
      chk($sformatf("basic_mul_b_k%0d", k), 32'(mul_b),     32'(exp_b[k]));
      tick();
    end
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    chk("basic_busy_done", 32'(busy),      32'd0);
    chk("basic_mul_a_done", 32'(mul_a),    32'd0);
    chk("basic_c_mat",     32'(c_mat),     32'(pack(3, 6, 7, 2)));
    tick();
    chk("basic_back_idle", 32'(in_ready),  32'd1);
    chk("basic_ov_low",    32'(out_valid), 32'd0);
    chk("basic_c_retain",  32'(c_mat),     32'(pack(3, 6, 7, 2)));

    // Maximum operands, then back-pressure while the result sits in DONE.
    a_mat = 8'hFF; b_mat = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("max_ov_early", 32'(out_valid), 32'd0);
    tick();
    chk("max_out_valid", 32'(out_valid), 32'd1);
    chk("max_c_mat",     32'(c_mat),     32'(pack(18, 18, 18, 18)));
    for (int n = 0; n < 5; n++) begin
      a_mat = 8'(n * 37); in_valid = n[0];
      tick();
      chk($sformatf("bp_ov_%0d", n), 32'(out_valid), 32'd1);
      chk($sformatf("bp_ir_%0d", n), 32'(in_ready),  32'd0);
      chk($sformatf("bp_c_%0d", n),  32'(c_mat),     32'(pack(18, 18, 18, 18)));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release_ov", 32'(out_valid), 32'd0);
    chk("bp_release_ir", 32'(in_ready),  32'd1);
    tick();
    chk("idle_stays",    32'(in_ready),  32'd1);

    // Reset in the middle of an operation, at k=4.
    a_mat = 8'h39; b_mat = 8'hC6; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("mid_mul_a_k4", 32'(mul_a), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",  32'(busy),  32'd0);
    chk("mid_rst_mul_a", 32'(mul_a), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_idle",  32'(in_ready),  32'd1);
    chk("mid_busy",  32'(busy),      32'd0);
    chk("mid_c_mat", 32'(c_mat),     32'd0);
    saw_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    chk("mid_no_out_valid", 32'(saw_valid), 32'd0);

    // New operation after the reset: A=[[0,1],[2,3]], B=[[3,2],[1,0]].
    a_mat = 8'hE4; b_mat = 8'h1B; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("post_c00_only", 32'(c_mat), 32'(pack(0, 0, 0, 1)));
    repeat (6) tick();
    chk("post_out_valid", 32'(out_valid), 32'd1);
    chk("post_c_mat",     32'(c_mat),     32'(pack(4, 9, 0, 1)));
    tick();

    // Back-to-back: in_valid is held high across two operations.
    a_mat = 8'h39; b_mat = 8'hC6; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    a_mat = 8'hFF; b_mat = 8'hFF;
    repeat (8) tick();
    chk("b2b_first_ov", 32'(out_valid), 32'd1);
    chk("b2b_first_c",  32'(c_mat),     32'(pack(3, 6, 7, 2)));
    tick();
    chk("b2b_idle_gap", 32'(in_ready),  32'd1);
    chk("b2b_gap_busy", 32'(busy),      32'd0);
    tick();
    chk("b2b_second_busy", 32'(busy),   32'd1);
    repeat (7) tick();
    chk("b2b_second_early", 32'(out_valid), 32'd0);
    tick();
    chk("b2b_second_ov", 32'(out_valid), 32'd1);
    chk("b2b_second_c",  32'(c_mat),     32'(pack(18, 18, 18, 18)));
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
